// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation datapath.
package ascon_pkg;

  localparam int ROUND_CONST_W = 8;
  localparam int MAX_ROUNDS    = 16;
  localparam int WORD_W        = 64;

  // Word 0 (S0) occupies the least significant 64 bits.
  typedef logic [4:0][WORD_W-1:0] ascon_state_t;
  typedef logic [4:0]             ascon_rnd_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} perm_fsm_e;

  // Round constant c_j = {3 - j, j + 12}, both nibbles taken modulo 16.
  function automatic logic [ROUND_CONST_W-1:0] ascon_rc(input logic [3:0] idx);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'd3 - idx;
    lo = idx + 4'd12;
    return {hi, lo};
  endfunction

  // Rotate a 64-bit word right by a constant amount.
  function automatic logic [WORD_W-1:0] ascon_ror(input logic [WORD_W-1:0] x,
                                                  input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t                s_in,
  input  logic [ROUND_CONST_W-1:0]    rc,
  output ascon_state_t                s_out
);

  logic [WORD_W-1:0] c2;
  logic [WORD_W-1:0] a0, a1, a2, a3, a4;
  logic [WORD_W-1:0] b0, b1, b2, b3, b4;
  logic [WORD_W-1:0] d0, d1, d2, d3, d4;

  // Constant addition into S2.
  assign c2 = s_in[2] ^ {{(WORD_W-ROUND_CONST_W){1'b0}}, rc};

  // S-box input mixing.
  assign a0 = s_in[0] ^ s_in[4];
  assign a1 = s_in[1];
  assign a2 = c2 ^ s_in[1];
  assign a3 = s_in[3];
  assign a4 = s_in[4] ^ s_in[3];

  // Chi-like nonlinear core.
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  // S-box output mixing.
  assign d0 = b0 ^ b4;
  assign d1 = b1 ^ b0;
  assign d2 = ~b2;
  assign d3 = b3 ^ b2;
  assign d4 = b4;

  // Per-word linear diffusion.
  assign s_out[0] = d0 ^ ascon_ror(d0, 19) ^ ascon_ror(d0, 28);
  assign s_out[1] = d1 ^ ascon_ror(d1, 61) ^ ascon_ror(d1, 39);
  assign s_out[2] = d2 ^ ascon_ror(d2, 1)  ^ ascon_ror(d2, 6);
  assign s_out[3] = d3 ^ ascon_ror(d3, 10) ^ ascon_ror(d3, 17);
  assign s_out[4] = d4 ^ ascon_ror(d4, 7)  ^ ascon_ror(d4, 41);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon-p[rnd] engine with valid/ready request and result handshakes.
// Optional macro ASCON_PERM_UNROLL2_EN: two chained rounds per cycle
// (odd counts finish with a single round); results are bit-identical.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 16,
  parameter int RND_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  ascon_state_t     in_state,
  input  logic [RND_W-1:0] in_rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output ascon_state_t     out_state,
  output logic             busy
);

  perm_fsm_e                 fsm;
  ascon_state_t              st;
  logic [3:0]                idx;
  ascon_rnd_t                rnd_eff;
  logic [3:0]                start_idx;
  logic                      accept;
  logic [ROUND_CONST_W-1:0]  rc0;
  ascon_state_t              st_r1;
  ascon_state_t              next_st;
  logic [3:0]                idx_step;
  logic                      run_last;

  // Counts above the constant schedule length saturate to the full permutation.
  function automatic ascon_rnd_t sat_rounds(input logic [RND_W-1:0] r);
    if (32'(r) > 32'(MAX_ROUNDS))
      return ascon_rnd_t'(MAX_ROUNDS);
    return ascon_rnd_t'(r);
  endfunction

  assign rnd_eff   = sat_rounds(in_rounds);
  // The schedule always ends at c15, so a short permutation starts late in it.
  assign start_idx = 4'(5'(MAX_ROUNDS) - rnd_eff);

  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_state = st;

  assign rc0 = ascon_rc(idx);

  ascon_round u_round0 (
    .s_in  (st),
    .rc    (rc0),
    .s_out (st_r1)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  logic [ROUND_CONST_W-1:0] rc1;
  ascon_state_t             st_r2;

  assign rc1 = ascon_rc(idx + 4'd1);

  ascon_round u_round1 (
    .s_in  (st_r1),
    .rc    (rc1),
    .s_out (st_r2)
  );

  // With idx at 15 only one round remains, so the second stage is skipped.
  assign next_st  = (idx == 4'd15) ? st_r1 : st_r2;
  assign idx_step = 4'd2;
  assign run_last = (idx >= 4'd14);
`else
  assign next_st  = st_r1;
  assign idx_step = 4'd1;
  assign run_last = (idx == 4'd15);
`endif

  // Sequencer: load on accept, iterate rounds in RUN, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      st        <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      st  <= in_state;
      idx <= start_idx;
      if (rnd_eff == '0) begin
        fsm       <= DONE;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        fsm       <= RUN;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
    end else begin
      case (fsm)
        RUN: begin
          st  <= next_st;
          idx <= idx + idx_step;
          if (run_last) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: a driver queues expected results,
// a monitor checks every presented result, its latency and its stability.
module tb_ascon_perm_ctrl;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  ascon_state_t in_state = '0;
  logic [4:0]   in_rounds = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  ascon_state_t out_state;
  logic         busy;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     rnd_ordy = 1'b0;

  typedef struct {
    ascon_state_t st;
    longint       acc;
    longint       lat;
  } exp_t;
  exp_t sb[$];

  logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic [7:0] RC_TAB [0:15] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  ascon_perm_ctrl #(.MAX_ROUNDS(16), .RND_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_rounds (in_rounds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Golden round: table-driven S-box applied column by column.
  function automatic ascon_state_t model_round(input ascon_state_t s, input int j);
    ascon_state_t t;
    logic [4:0]   col;
    logic [4:0]   o;
    s[2][7:0] = s[2][7:0] ^ RC_TAB[j];
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o   = SBOX[col];
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
    s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
    s[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
    s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
    s[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    return s;
  endfunction

  function automatic ascon_state_t model_perm(input ascon_state_t s, input int r);
    int reff;
    reff = (r > 16) ? 16 : r;
    for (int j = 16 - reff; j < 16; j++) s = model_round(s, j);
    return s;
  endfunction

  // Edges from the accept edge to the edge after which out_valid is high.
  function automatic longint exp_lat(input int r);
    int reff;
    reff = (r > 16) ? 16 : r;
`ifdef ASCON_PERM_UNROLL2_EN
    return longint'((reff + 1) / 2);
`else
    return longint'(reff);
`endif
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input ascon_state_t s, input int r, input ascon_state_t e);
    bit   ok;
    exp_t x;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_state  = s;
    in_rounds = 5'(r);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      x.st  = e;
      x.acc = cyc + 1;
      x.lat = exp_lat(r);
      sb.push_back(x);
      @(posedge clk);
      #1;
    end else begin
      chk_int("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare the queue head whenever a result is presented.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk_int("spurious_out_valid", 1, 0);
        end else begin
          if (!seen) begin
            chk_int("latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1'b1;
          end
          chk("out_state", out_state, sb[0].st);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ascon_state_t z, pat, hand1, s1, s2, rs;
    int           r;
    bit           got;
    z   = '0;
    pat = {64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978, 64'h8899aabbccddeeff,
           64'h1122334455667788, 64'h0123456789abcdef};
    // p[1] of the all-zero state, worked out by hand from c15 = 0x4b.
    hand1 = {64'h0000000000000000, 64'h12e580000000004b, 64'h53ffffffffffff90,
             64'h0000000096000213, 64'h000964b00000004b};

    // Reset values.
    repeat (2) @(negedge clk);
    chk_int("reset_out_valid", out_valid, 0);
    chk_int("reset_in_ready", in_ready, 1);
    chk_int("reset_busy", busy, 0);
    chk("reset_out_state", out_state, z);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // p[12] on zero state with ready watch across the run.
    send(z, 12, model_perm(z, 12));
    for (int k = 0; k < int'(exp_lat(12)); k++) begin
      @(negedge clk);
      chk_int("run_in_ready", in_ready, 0);
      chk_int("run_busy", busy, 1);
    end
    @(negedge clk);
    chk_int("done_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Shorter and degenerate round counts.
    send(z, 8, model_perm(z, 8));
    send(z, 6, model_perm(z, 6));
    send(z, 1, hand1);
    send(pat, 0, pat);
    send(z, 20, model_perm(z, 16));
    send(pat, 16, model_perm(pat, 16));
    send(pat, 31, model_perm(pat, 16));
    repeat (20) @(posedge clk);
    #1;

    // Backpressure in DONE with a waiting request.
    s1 = pat;
    s2 = ~pat;
    out_ready = 1'b0;
    send(s1, 4, model_perm(s1, 4));
    fork
      send(s2, 3, model_perm(s2, 3));
      begin
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) begin
            got = 1'b1;
            break;
          end
        end
        chk_int("hold_reached_done", got, 1);
        chk_int("hold_in_ready", in_ready, 0);
        repeat (4) begin
          @(negedge clk);
          chk_int("hold_in_ready", in_ready, 0);
          chk_int("hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of p[12], then a clean p[8].
    send(pat, 12, model_perm(pat, 12));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_int("midreset_out_valid", out_valid, 0);
    chk_int("midreset_in_ready", in_ready, 1);
    chk_int("midreset_busy", busy, 0);
    chk("midreset_out_state", out_state, z);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(pat, 8, model_perm(pat, 8));
    repeat (12) @(posedge clk);
    #1;

    // Random states and round counts under random backpressure.
    rnd_ordy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 5; w++) rs[w] = {$urandom, $urandom};
      r = int'($urandom_range(0, 20));
      send(rs, r, model_perm(rs, r));
    end
    rnd_ordy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk_int("drain_pending", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
